// File: rtl/fft_output_serializer_pkg.sv
// Shared definitions for the FFT output serializer: FSM encoding, index
// width limits and the bit-reversal helper used for the write addressing.
package fft_pkg;

    // Largest supported FFT is 4096 points, so indices never exceed 12 bits.
    localparam int MAX_IDX_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_IDX_W-1:0] bitrev(input logic [MAX_IDX_W-1:0] v,
                                                    input int w);
        logic [MAX_IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_IDX_W; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_output_serializer_if.sv
// Bundle between the FFT core / consumer side (master) and the serializer
// (slave).
//
// Handshake rules: the input pair side has no backpressure -- a pair is
// taken on every cycle in_valid_i is high while capturing. The output side
// is a strict valid/ready stream: a sample transfers on a rising clk edge
// where out_valid_o && out_ready_i; while out_valid_o is high and
// out_ready_i is low, out_re_o/out_im_o/out_idx_o/out_last_o stay constant
// and out_valid_o does not drop.
interface fft_out_if #(
    parameter int N  = 1024,
    parameter int DW = 32
);
    localparam int IW = $clog2(N);

    logic          fft_ready_i;
    logic          in_valid_i;
    logic [DW-1:0] x0_re_i;
    logic [DW-1:0] x0_im_i;
    logic [DW-1:0] x1_re_i;
    logic [DW-1:0] x1_im_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_re_o;
    logic [DW-1:0] out_im_o;
    logic [IW-1:0] out_idx_o;
    logic          out_last_o;
    logic          busy_o;
    logic          overflow_o;

    modport master (
        output fft_ready_i, in_valid_i, x0_re_i, x0_im_i, x1_re_i, x1_im_i,
        output out_ready_i,
        input  out_valid_o, out_re_o, out_im_o, out_idx_o, out_last_o,
        input  busy_o, overflow_o
    );

    modport slave (
        input  fft_ready_i, in_valid_i, x0_re_i, x0_im_i, x1_re_i, x1_im_i,
        input  out_ready_i,
        output out_valid_o, out_re_o, out_im_o, out_idx_o, out_last_o,
        output busy_o, overflow_o
    );

endinterface

// File: rtl/fft_output_serializer_ram.sv
// Reorder buffer: DEPTH words, two writes per cycle (the two bins of one
// butterfly pair, which never share an address) and one synchronous read.
// Kept separate so a vendor BRAM macro can replace it.
module fft_reorder_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int W     = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa0,
    input  logic [AW-1:0] wa1,
    input  logic [W-1:0]  wd0,
    input  logic [W-1:0]  wd1,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rd
);
    logic [W-1:0] mem [DEPTH];

    // Store both bins of the incoming pair.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa0] <= wd0;
            mem[wa1] <= wd1;
        end
    end

    // Registered read; the word holds while re is low, so it doubles as
    // the output sample register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rd <= '0;
        else if (re) rd <= mem[ra];
    end

endmodule

// File: rtl/fft_output_serializer.sv
// Captures N/2 butterfly pairs from the FFT core into a reorder buffer at
// their natural bin addresses, then streams bins 0..N-1 out over valid/ready.
module fft_output_serializer
    import fft_pkg::*;
#(
    parameter int N           = 1024,
    parameter int DW          = 32,
    parameter int BIT_REVERSE = 1
) (
    input  logic       clk,
    input  logic       rst,
    fft_out_if.slave   bus
);
    localparam int IW   = $clog2(N);
    localparam int PW   = IW - 1;
    localparam int HALF = N / 2;

    state_t        state;
    logic [PW-1:0] k;
    logic [IW-1:0] r;
    logic          ready_q;
    logic          out_valid;
    logic          out_last;
    logic [IW-1:0] out_idx;
    logic          overflow;
    logic [2*DW-1:0] rd_word;

    logic          rise;
    logic          wr_en;
    logic          last_hs;
    logic          load;
    logic [IW-1:0] lin0;
    logic [IW-1:0] lin1;
    logic [IW-1:0] a0;
    logic [IW-1:0] a1;

    assign rise  = bus.fft_ready_i & ~ready_q;
    assign wr_en = (state == CAPTURE) && bus.in_valid_i;

    // Natural positions of the pair slot, then optionally bit-reversed.
    assign lin0 = {k, 1'b0};
    assign lin1 = {k, 1'b1};
    assign a0   = (BIT_REVERSE != 0) ? IW'(bitrev(MAX_IDX_W'(lin0), IW)) : lin0;
    assign a1   = (BIT_REVERSE != 0) ? IW'(bitrev(MAX_IDX_W'(lin1), IW)) : lin1;

    // A new sample is fetched whenever the output slot is empty or being
    // consumed, except when the sample being consumed is the final bin.
    assign last_hs = out_valid && bus.out_ready_i && out_last;
    assign load    = (state == DRAIN) && (!out_valid || bus.out_ready_i) && !last_hs;

    fft_reorder_ram #(
        .DEPTH (N),
        .AW    (IW),
        .W     (2*DW)
    ) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (wr_en),
        .wa0 (a0),
        .wa1 (a1),
        .wd0 ({bus.x0_re_i, bus.x0_im_i}),
        .wd1 ({bus.x1_re_i, bus.x1_im_i}),
        .re  (load),
        .ra  (r),
        .rd  (rd_word)
    );

    // Frame control: arm on a fft_ready rise, count pairs in, then walk the
    // buffer in natural order with registered valid/idx/last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            r         <= '0;
            ready_q   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            overflow  <= 1'b0;
        end else begin
            ready_q <= bus.fft_ready_i;
            if (bus.in_valid_i && (state != CAPTURE)) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= CAPTURE;
                        k     <= '0;
                    end
                end
                CAPTURE: begin
                    if (bus.in_valid_i) begin
                        k <= k + 1'b1;
                        if (k == PW'(HALF - 1)) begin
                            state <= DRAIN;
                            r     <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else if (load) begin
                        out_valid <= 1'b1;
                        out_idx   <= r;
                        out_last  <= (r == IW'(N - 1));
                        r         <= r + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid_o = out_valid;
    assign bus.out_re_o    = rd_word[2*DW-1:DW];
    assign bus.out_im_o    = rd_word[DW-1:0];
    assign bus.out_idx_o   = out_idx;
    assign bus.out_last_o  = out_last;
    assign bus.busy_o      = (state != IDLE);
    assign bus.overflow_o  = overflow;

endmodule

// File: tb/tb_fft_output_serializer.sv
// Bench for fft_output_serializer: three instances (N=8 bit-reversed,
// N=8 natural, N=1024 bit-reversed) share one set of driven signals, gated
// by sel. Frames are modelled as arrays of natural-order bins.
module tb_fft_output_serializer;
    localparam int DW = 32;
    localparam int EW = 12 + 2*DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared drive signals ----------------
    logic [1:0]    sel = 2'd0;
    logic          fft_ready = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] x0_re = '0, x0_im = '0, x1_re = '0, x1_im = '0;

    fft_out_if #(.N(8),    .DW(DW)) bus_a();
    fft_out_if #(.N(8),    .DW(DW)) bus_b();
    fft_out_if #(.N(1024), .DW(DW)) bus_c();

    assign bus_a.fft_ready_i = fft_ready && (sel == 2'd0);
    assign bus_a.in_valid_i  = in_valid  && (sel == 2'd0);
    assign bus_a.out_ready_i = out_ready && (sel == 2'd0);
    assign bus_a.x0_re_i = x0_re;
    assign bus_a.x0_im_i = x0_im;
    assign bus_a.x1_re_i = x1_re;
    assign bus_a.x1_im_i = x1_im;
    assign bus_b.fft_ready_i = fft_ready && (sel == 2'd1);
    assign bus_b.in_valid_i  = in_valid  && (sel == 2'd1);
    assign bus_b.out_ready_i = out_ready && (sel == 2'd1);
    assign bus_b.x0_re_i = x0_re;
    assign bus_b.x0_im_i = x0_im;
    assign bus_b.x1_re_i = x1_re;
    assign bus_b.x1_im_i = x1_im;
    assign bus_c.fft_ready_i = fft_ready && (sel == 2'd2);
    assign bus_c.in_valid_i  = in_valid  && (sel == 2'd2);
    assign bus_c.out_ready_i = out_ready && (sel == 2'd2);
    assign bus_c.x0_re_i = x0_re;
    assign bus_c.x0_im_i = x0_im;
    assign bus_c.x1_re_i = x1_re;
    assign bus_c.x1_im_i = x1_im;

    fft_output_serializer #(.N(8),    .DW(DW), .BIT_REVERSE(1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    fft_output_serializer #(.N(8),    .DW(DW), .BIT_REVERSE(0)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
    fft_output_serializer #(.N(1024), .DW(DW), .BIT_REVERSE(1)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

    // Selected instance outputs
    logic          o_valid, o_last, o_busy, o_ovf;
    logic [11:0]   o_idx;
    logic [DW-1:0] o_re, o_im;
    always_comb begin
        o_valid = bus_a.out_valid_o; o_last = bus_a.out_last_o; o_busy = bus_a.busy_o;
        o_ovf = bus_a.overflow_o; o_idx = 12'(bus_a.out_idx_o);
        o_re = bus_a.out_re_o; o_im = bus_a.out_im_o;
        if (sel == 2'd1) begin
            o_valid = bus_b.out_valid_o; o_last = bus_b.out_last_o; o_busy = bus_b.busy_o;
            o_ovf = bus_b.overflow_o; o_idx = 12'(bus_b.out_idx_o);
            o_re = bus_b.out_re_o; o_im = bus_b.out_im_o;
        end else if (sel == 2'd2) begin
            o_valid = bus_c.out_valid_o; o_last = bus_c.out_last_o; o_busy = bus_c.busy_o;
            o_ovf = bus_c.overflow_o; o_idx = 12'(bus_c.out_idx_o);
            o_re = bus_c.out_re_o; o_im = bus_c.out_im_o;
        end
    end

    // ---------------- model / scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    int            n = 8;
    bit            br = 1'b1;
    logic [DW-1:0] val_re [1024];
    logic [DW-1:0] val_im [1024];
    logic [EW-1:0] exp_q [$];
    int            hs_total = 0;
    int            base = 0;
    bit            mon_en = 1'b0;
    bit            frame_on = 1'b0;
    logic [DW-1:0] last_re = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Bin index whose bits are those of v read backwards over 'bits' bits.
    function automatic int rev(input int v, input int bits);
        int res = 0;
        for (int i = 0; i < bits; i++) res = (res << 1) | ((v >> i) & 1);
        return res;
    endfunction

    // ---------------- compare process ----------------
    initial begin
        bit            prev_stall;
        logic [DW-1:0] prev_re, prev_im;
        logic [11:0]   prev_idx;
        logic          prev_last;
        logic [EW-1:0] e;
        prev_stall = 1'b0;
        prev_re = '0; prev_im = '0; prev_idx = '0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(o_valid), 64'd1);
                    check("hold_re",    64'(o_re),    64'(prev_re));
                    check("hold_im",    64'(o_im),    64'(prev_im));
                    check("hold_idx",   64'(o_idx),   64'(prev_idx));
                    check("hold_last",  64'(o_last),  64'(prev_last));
                end
                if (frame_on) check("busy_in_frame", 64'(o_busy), 64'd1);
                if (o_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_sample actual idx=%0d required none", o_idx);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_idx",  64'(o_idx),  64'(e[EW-1:2*DW]));
                        check("out_re",   64'(o_re),   64'(e[2*DW-1:DW]));
                        check("out_im",   64'(o_im),   64'(e[DW-1:0]));
                        check("out_last", 64'(o_last), 64'(int'(e[EW-1:2*DW]) == n - 1));
                        last_re = o_re;
                        hs_total++;
                    end
                end
                prev_stall = o_valid && !out_ready;
                prev_re = o_re; prev_im = o_im; prev_idx = o_idx; prev_last = o_last;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic select(input int s);
        sel = 2'(s);
        n   = (s == 2) ? 1024 : 8;
        br  = (s != 1);
    endtask

    task automatic arm();
        fft_ready = 1'b0;
        @(posedge clk); #1;
        fft_ready = 1'b1;
        @(posedge clk); #1;
        check("busy_arm", 64'(o_busy), 64'd1);
        frame_on = 1'b1;
    endtask

    // Build a frame in natural order, queue the expected stream, then feed
    // the pairs in the order the core would emit them.
    task automatic send_frame(input int gap, input bit rnd);
        int lg, a0, a1;
        lg = $clog2(n);
        base = hs_total;
        for (int b = 0; b < n; b++) begin
            val_re[b] = rnd ? DW'($urandom) : DW'(100 + b);
            val_im[b] = rnd ? DW'($urandom) : DW'(200 + b);
            exp_q.push_back({12'(b), val_re[b], val_im[b]});
        end
        for (int k = 0; k < n / 2; k++) begin
            a0 = br ? rev(2 * k, lg)     : 2 * k;
            a1 = br ? rev(2 * k + 1, lg) : 2 * k + 1;
            in_valid = 1'b1;
            x0_re = val_re[a0]; x0_im = val_im[a0];
            x1_re = val_re[a1]; x1_im = val_im[a1];
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (k != n / 2 - 1) repeat (gap) @(posedge clk);
            if (k != n / 2 - 1 && gap > 0) #1;
        end
        check("latency_gap", 64'(o_valid), 64'd0);
        @(posedge clk); #1;
        check("latency_first", 64'(o_valid), 64'd1);
    endtask

    task automatic drain(input int mode, input int stop_at);
        int budget;
        budget = 8 * n + 50;
        while ((hs_total - base) < stop_at && budget > 0) begin
            @(posedge clk); #1;
            budget--;
            if ((hs_total - base) >= stop_at) break;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
        if ((hs_total - base) < stop_at) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=%0d handshakes", hs_total - base, stop_at);
        end
    endtask

    task automatic full_frame(input int gap, input bit rnd, input int mode);
        arm();
        out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        send_frame(gap, rnd);
        drain(mode, n);
        check("done_valid", 64'(o_valid), 64'd0);
        check("done_busy",  64'(o_busy),  64'd0);
        check("done_count", 64'(hs_total - base), 64'(n));
        check("done_queue", 64'(exp_q.size()), 64'd0);
        frame_on = 1'b0;
        out_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        check("model_rev1", 64'(rev(1, 3)), 64'd4);
        check("model_rev3", 64'(rev(3, 3)), 64'd6);
        check("model_rev6", 64'(rev(6, 3)), 64'd3);

        do_reset();
        select(0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_busy",  64'(o_busy),  64'd0);
        check("rst_ovf",   64'(o_ovf),   64'd0);
        check("rst_re",    64'(o_re),    64'd0);
        check("rst_idx",   64'(o_idx),   64'd0);
        check("rst_last",  64'(o_last),  64'd0);
        mon_en = 1'b1;

        // Bit-reversed N=8 frame, consumer always ready
        full_frame(0, 1'b0, 0);
        check("lit_last_re", 64'(last_re), 64'd107);

        // fft_ready still high: no new frame without a fall
        repeat (4) @(posedge clk);
        #1 check("no_rearm", 64'(o_busy), 64'd0);

        // Same frame with the consumer stalling every other cycle
        full_frame(0, 1'b0, 1);
        check("lit_last_re_stall", 64'(last_re), 64'd107);

        // Natural pair order, 3-cycle gaps between pairs
        select(1);
        full_frame(3, 1'b0, 0);
        check("lit_last_re_nat", 64'(last_re), 64'd107);

        // Stray pair in IDLE flags overflow, which then persists
        select(0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ovf_set", 64'(o_ovf), 64'd1);
        full_frame(1, 1'b1, 2);
        check("ovf_sticky", 64'(o_ovf), 64'd1);

        // Reset in the middle of a drain, then a clean frame
        arm();
        out_ready = 1'b1;
        send_frame(0, 1'b1);
        drain(0, 3);
        mon_en = 1'b0;
        frame_on = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_re",    64'(o_re),    64'd0);
        check("arst_im",    64'(o_im),    64'd0);
        check("arst_idx",   64'(o_idx),   64'd0);
        check("arst_last",  64'(o_last),  64'd0);
        check("arst_busy",  64'(o_busy),  64'd0);
        check("arst_ovf",   64'(o_ovf),   64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        full_frame(0, 1'b1, 1);

        // Full-size random frame with random backpressure
        select(2);
        full_frame(0, 1'b1, 2);
        check("n1024_ovf", 64'(bus_c.overflow_o), 64'd0);
        check("n8nat_ovf", 64'(bus_b.overflow_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_output_serializer.md
Name: fft_output_serializer

Overview:
- Downstream neighbour of the FFT core: captures the N/2 butterfly output pairs (x0/x1, re/im) the core streams after fft_ready asserts, then replays the N bins one per cycle in natural order over a valid/ready stream.
- Removes the core's bit-reversed pair ordering so the consumer (magnitude stage, UART/AXI dump) sees bin 0..N-1 sequentially.
- Single clock domain, same clock as the FFT core.

Parameters:
- N, 1024, FFT length; power of two, 8 to 4096.
- DW, 32, width of each real/imag word.
- BIT_REVERSE, 1, 1: pair k carries bins bitrev(2k) and bitrev(2k+1); 0: pair k carries bins 2k and 2k+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fft_ready_i  in  1  level from core; rising edge arms capture.
- in_valid_i  in  1  pair on x0/x1 inputs valid this cycle.
- x0_re_i  in  DW  first bin of pair, real.
- x0_im_i  in  DW  first bin of pair, imaginary.
- x1_re_i  in  DW  second bin of pair, real.
- x1_im_i  in  DW  second bin of pair, imaginary.
- out_valid_o  out  1  output sample valid.
- out_ready_i  in  1  consumer accepts sample.
- out_re_o  out  DW  output real part.
- out_im_o  out  DW  output imaginary part.
- out_idx_o  out  $clog2(N)  natural bin index of output.
- out_last_o  out  1  high with bin N-1.
- busy_o  out  1  state != IDLE.
- overflow_o  out  1  sticky: pair offered while not capturing.

Behaviour:
- Reset (async, any time): state IDLE, counters 0, out_valid_o=0, out_last_o=0, out_re/im/idx=0, busy_o=0, overflow_o=0. Reset mid-capture or mid-drain abandons the frame; buffer contents are don't-care.
- Storage: N x (2*DW) register array, one write port with two writes per cycle (even/odd bank split: bank0 holds even natural indices, bank1 odd, or equivalent), one synchronous read port.
- IDLE: a rising edge on fft_ready_i (registered compare) -> CAPTURE, pair counter k=0. in_valid_i in IDLE or DRAIN is ignored and sets overflow_o.
- CAPTURE: each in_valid_i cycle writes x0 to address a0 and x1 to address a1, k++. BIT_REVERSE=1: a0=bitrev(2k), a1=bitrev(2k+1) over $clog2(N) bits; BIT_REVERSE=0: a0=2k, a1=2k+1. After pair k=N/2-1 is written -> DRAIN with read index r=0. No backpressure on the input side; in_valid_i gaps are allowed.
- DRAIN: read latency 1 cycle; out_valid_o first asserts 2 cycles after the last pair write (1 for the state change, 1 for the read). Output register holds re/im/idx/last stable while out_valid_o && !out_ready_i. On handshake (valid && ready) r advances; with out_ready_i held high, one sample per cycle, no bubbles (prefetch next address on handshake). out_last_o=1 exactly when out_idx_o=N-1. Handshake on last -> IDLE; out_valid_o deasserts next cycle.
- fft_ready_i rising during CAPTURE/DRAIN is ignored (no re-arm, no error).
- fft_ready_i held high across frames: a new frame needs a fall then a rise.
- overflow_o is cleared only by rst.
- Index arithmetic: unsigned, wraps modulo N; counters sized $clog2(N) (pair counter $clog2(N)-1).

Decomposition:
- Shared package fft_pkg: clog2-derived index widths, complex sample typedef {re,im} of DW, state encoding enum (IDLE, CAPTURE, DRAIN), bitrev function.
- One sub-module natural: fft_reorder_ram (dual-write/single-read sample buffer, synchronous read), so FPGA BRAM inference can be swapped in.

Test Plan:
- N=8, BIT_REVERSE=1, fft_ready rise, 4 pairs with value = 100+natural-bin at addresses (0,4),(2,6),(1,5),(3,7), out_ready=1 -> out_idx 0..7 consecutive cycles, out_re=100..107, out_last only on idx 7, first valid 2 cycles after last pair.
- Same frame, out_ready toggled 1/0 each cycle -> each sample held stable while stalled, no drop/duplicate, 8 handshakes total, returns IDLE.
- BIT_REVERSE=0, pairs (2k,2k+1) with in_valid gaps of 3 cycles -> natural output unchanged, busy_o high from arm to last handshake.
- in_valid_i pulsed in IDLE -> overflow_o=1 and stays 1 through a full subsequent frame; frame data still correct.
- rst asserted mid-DRAIN after 3 samples -> all outputs 0 asynchronously, busy_o=0; next fft_ready rise captures and drains a fresh frame correctly.
- N=1024 random data vs reference model bit-reversal -> all 1024 bins match, out_last on idx 1023.
